nv_nvdla_cdma_wt_fifo_arb: RTL and testbench
============================================

# nv_nvdla_cdma_wt_fifo_arb

Packet-level write-side arbiter for the CDMA 128x6 weight FIFO. It shares the FIFO's single write port between two weight-request sources (src0: weight fetch, src1: WMB fetch). It holds the grant for a whole packet and throttles writes against a programmable occupancy watermark. It sits directly in front of the FIFO write port and snoops the FIFO read handshake to track occupancy.

## Interface
Parameters:
- DW, 6, data width of one FIFO entry
- DEPTH, 128, FIFO depth in entries
- CW, 8, occupancy counter width, large enough to hold DEPTH
- PW, 16, width of each per-source packet counter

Ports:
- clk  in  1  single clock; every flop is on posedge clk
- reset_  in  1  synchronous, active-low reset, sampled on posedge clk
- src0_req / src1_req  in  1  source has a valid beat
- src0_data / src1_data  in  DW  beat payload
- src0_last / src1_last  in  1  beat is the last beat of its packet
- src0_ready / src1_ready  out  1  beat accepted this cycle
- fifo_wr_req  out  1  write request to the FIFO
- fifo_wr_data  out  DW  write payload
- fifo_wr_ready  in  1  FIFO write-side ready
- fifo_rd_req / fifo_rd_ready  in  1  snooped FIFO read handshake; a pop is rd_req && rd_ready
- cfg_prio  in  1  1 = fixed priority to src0; 0 = round-robin
- cfg_wmark  in  CW  throttle threshold; 0 = disabled, only the DEPTH limit applies
- occ_count  out  CW  current occupancy as seen from the write side
- pkt_cnt0 / pkt_cnt1  out  PW  completed packets per source, wrapping
- arb_busy  out  1  state is not IDLE

## Operation
- State machine states: IDLE, GNT0, GNT1.
- Transitions out of IDLE:
  - Only src0_req: go to GNT0.
  - Only src1_req: go to GNT1.
  - Both requesting with cfg_prio=1: go to GNT0.
  - Both requesting with cfg_prio=0: grant the source that is not rr_last.
- Transition out of GNTx: return to IDLE on the cycle a beat with srcx_last=1 is accepted.
- Beat accept is fifo_wr_req && fifo_wr_ready.
- Write-port outputs in GNTx:
  - fifo_wr_req = srcx_req && !throttle.
  - fifo_wr_data = srcx_data.
  - srcx_ready = fifo_wr_ready && !throttle.
  - The other source's ready is 0.
- In IDLE, both readies are 0 and fifo_wr_req is 0.
- When fifo_wr_req is 0, fifo_wr_data is 0.
- throttle = (occ_count == DEPTH) || (cfg_wmark != 0 && occ_count >= cfg_wmark).
  - Throttle stalls the current beat; the grant is held and never reassigned mid-packet.
- rr_last: on completion of a packet from source x, rr_last <= x.
- occ_count update:
  - Increment on an accepted beat.
  - Decrement on a pop.
  - Both in the same cycle: unchanged.
  - Decrement at 0 and increment at DEPTH cannot occur (guarded by throttle and the FIFO protocol); the bench asserts both.
- pkt_cntx increments on completion of a packet from source x and wraps at 2^PW.
- Configuration changes take effect on the next arbitration decision. A cfg_wmark change acts immediately on throttle.

## Timing
- Reset values:
  - State: IDLE.
  - rr_last: 1, so src0 wins the first round-robin tie.
  - occ_count, pkt_cnt0, pkt_cnt1: 0.
  - fifo_wr_req, srcx_ready, arb_busy: 0.
  - fifo_wr_data: 0.
- Arbitration latency:
  - A request seen in IDLE at cycle N gives GNTx at N+1.
  - The earliest first-beat accept is N+1.
- Write-port outputs are combinational from state, source inputs, fifo_wr_ready and registered occ_count. No path goes from fifo_wr_ready to state within the same cycle except through accept.
- Sustained throughput:
  - Single-beat packets: one beat every 2 cycles, because of the IDLE bubble.
  - Multi-beat packets: one beat per cycle within a packet.
- occ_count reflects accepts and pops one cycle after they occur, so throttle is registered-conservative.
- If reset_ is asserted mid-packet, the packet is abandoned and every register returns to its reset value on the next clock edge. The source must restart the packet.

## Structure
- Shared package nv_nvdla_cdma_wt_arb_pkg holds:
  - The state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2).
  - Default constants for DW, DEPTH and CW.
- One sub-module, nv_nvdla_cdma_wt_occ_cnt: an up/down occupancy counter with simultaneous inc/dec and throttle compare. It is reusable for the other CDMA FIFOs.
- Arbitration FSM, round-robin pointer and packet counters stay in the top module.

## Test plan
- src0 sends a 3-beat packet and src1 is idle, with fifo_wr_ready=1:
  - GNT0 one cycle after the request; beats are accepted on 3 consecutive cycles.
  - Then IDLE; pkt_cnt0=1; occ_count=3.
- Both sources request 1-beat packets continuously with cfg_prio=0:
  - Grants alternate src0, src1, src0, …
  - One beat every 2 cycles.
- Both sources request with cfg_prio=1:
  - src0 wins every decision; src1 is starved until src0_req drops.
- cfg_wmark=4, no pops, src1 sends a 6-beat packet:
  - 4 beats are accepted, then fifo_wr_req=0 and src1_ready=0 with the grant held.
  - Two pops bring occ_count from 4 to 2; the remaining 2 beats complete and occ_count ends at 4.
- Accept and pop in the same cycle at occ_count=10 -> occ_count stays 10.
- Mid-packet reset after 2 of 5 beats:
  - Next cycle: IDLE, occ_count=0, all readies 0, pkt_cnt unchanged from its reset value 0.

Source files
------------

// File: rtl/nv_nvdla_cdma_wt_arb_pkg.sv
// Shared constants for the CDMA weight-FIFO write arbiter: state encoding and default sizes.
package nv_nvdla_cdma_wt_arb_pkg;
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_GNT0 = 2'd1;
  localparam arb_state_t ST_GNT1 = 2'd2;

  localparam int DEF_DW    = 6;
  localparam int DEF_DEPTH = 128;
  localparam int DEF_CW    = 8;
endpackage

// File: rtl/nv_nvdla_cdma_wt_occ_cnt.sv
// Up/down FIFO occupancy counter with watermark throttle; shared by the CDMA FIFO front-ends.
module nv_nvdla_cdma_wt_occ_cnt #(
  parameter int CW    = 8,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          inc,
  input  logic          dec,
  input  logic [CW-1:0] wmark,
  output logic [CW-1:0] count,
  output logic          throttle
);
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec)      count_d = count_q + CW'(1);
    else if (dec && !inc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count = count_q;
  // Compare against the registered count only, so throttle never depends on this cycle's accept.
  assign throttle = (count_q == CW'(DEPTH)) || ((wmark != '0) && (count_q >= wmark));
endmodule

// File: rtl/nv_nvdla_cdma_wt_fifo_arb.sv
// Packet-level arbiter sharing the weight FIFO write port between weight fetch and WMB fetch.
module nv_nvdla_cdma_wt_fifo_arb
  import nv_nvdla_cdma_wt_arb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW,
  parameter int PW    = 16
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          src0_req,
  input  logic [DW-1:0] src0_data,
  input  logic          src0_last,
  output logic          src0_ready,
  input  logic          src1_req,
  input  logic [DW-1:0] src1_data,
  input  logic          src1_last,
  output logic          src1_ready,
  output logic          fifo_wr_req,
  output logic [DW-1:0] fifo_wr_data,
  input  logic          fifo_wr_ready,
  input  logic          fifo_rd_req,
  input  logic          fifo_rd_ready,
  input  logic          cfg_prio,
  input  logic [CW-1:0] cfg_wmark,
  output logic [CW-1:0] occ_count,
  output logic [PW-1:0] pkt_cnt0,
  output logic [PW-1:0] pkt_cnt1,
  output logic          arb_busy
);
  arb_state_t    state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic [PW-1:0] pkt_cnt0_q, pkt_cnt0_d, pkt_cnt1_q, pkt_cnt1_d;
  logic          throttle, accept, pop, done0, done1;

  assign accept = fifo_wr_req && fifo_wr_ready;
  assign pop    = fifo_rd_req && fifo_rd_ready;

  nv_nvdla_cdma_wt_occ_cnt #(.CW(CW), .DEPTH(DEPTH)) u_occ (
    .clk      (clk),
    .reset_   (reset_),
    .inc      (accept),
    .dec      (pop),
    .wmark    (cfg_wmark),
    .count    (occ_count),
    .throttle (throttle)
  );

  always_comb begin
    fifo_wr_req = 1'b0;
    src0_ready  = 1'b0;
    src1_ready  = 1'b0;
    case (state_q)
      ST_GNT0: begin
        fifo_wr_req = src0_req && !throttle;
        src0_ready  = fifo_wr_ready && !throttle;
      end
      ST_GNT1: begin
        fifo_wr_req = src1_req && !throttle;
        src1_ready  = fifo_wr_ready && !throttle;
      end
      default: ;
    endcase
  end

  assign fifo_wr_data = !fifo_wr_req          ? '0 :
                        (state_q == ST_GNT1)  ? src1_data : src0_data;

  assign done0 = (state_q == ST_GNT0) && accept && src0_last;
  assign done1 = (state_q == ST_GNT1) && accept && src1_last;

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    case (state_q)
      // On a round-robin tie src0 wins when src1 completed the last packet (rr_last=1).
      ST_IDLE: begin
        if (src0_req && (!src1_req || cfg_prio || rr_last_q)) state_d = ST_GNT0;
        else if (src1_req)                                     state_d = ST_GNT1;
      end
      ST_GNT0: if (done0) state_d = ST_IDLE;
      ST_GNT1: if (done1) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (done0) begin
      rr_last_d  = 1'b0;
      pkt_cnt0_d = pkt_cnt0_q + PW'(1);
    end
    if (done1) begin
      rr_last_d  = 1'b1;
      pkt_cnt1_d = pkt_cnt1_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      rr_last_q  <= 1'b1;
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign arb_busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_nv_nvdla_cdma_wt_fifo_arb.sv
// Bench for the weight-FIFO write arbiter: packet-level reference model, per-cycle compare, directed pins.
module tb_nv_nvdla_cdma_wt_fifo_arb;
  localparam int DW = 6, DEPTH = 128, CW = 8, PW = 16;

  logic          clk = 1'b0;
  logic          reset_;
  logic          src0_req, src0_last, src0_ready, src1_req, src1_last, src1_ready;
  logic [DW-1:0] src0_data, src1_data, fifo_wr_data;
  logic          fifo_wr_req, fifo_wr_ready, fifo_rd_req, fifo_rd_ready;
  logic          cfg_prio, arb_busy;
  logic [CW-1:0] cfg_wmark, occ_count;
  logic [PW-1:0] pkt_cnt0, pkt_cnt1;

  nv_nvdla_cdma_wt_fifo_arb #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .PW(PW)) dut (
    .clk(clk), .reset_(reset_),
    .src0_req(src0_req), .src0_data(src0_data), .src0_last(src0_last), .src0_ready(src0_ready),
    .src1_req(src1_req), .src1_data(src1_data), .src1_last(src1_last), .src1_ready(src1_ready),
    .fifo_wr_req(fifo_wr_req), .fifo_wr_data(fifo_wr_data), .fifo_wr_ready(fifo_wr_ready),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_ready(fifo_rd_ready),
    .cfg_prio(cfg_prio), .cfg_wmark(cfg_wmark), .occ_count(occ_count),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: owner of the write port, fairness pointer, counts
  int  m_own = -1, m_rr = 1, m_occ = 0, m_pc0 = 0, m_pc1 = 0, cyc_n = 0;
  bit  started = 0;

  function automatic bit m_thr();
    return (m_occ == DEPTH) || (cfg_wmark != 0 && m_occ >= int'(cfg_wmark));
  endfunction

  always @(posedge clk) begin
    int  acc, pp;
    bit  lst;
    cyc_n++;
    if (!reset_) begin
      m_own = -1; m_rr = 1; m_occ = 0; m_pc0 = 0; m_pc1 = 0; started = 1;
    end else if (started) begin
      acc = 0; lst = 0;
      if (m_own == 0 && src0_req && !m_thr() && fifo_wr_ready) begin acc = 1; lst = src0_last; end
      if (m_own == 1 && src1_req && !m_thr() && fifo_wr_ready) begin acc = 1; lst = src1_last; end
      pp = (fifo_rd_req && fifo_rd_ready) ? 1 : 0;
      if (pp == 1 && m_occ == 0) chk("occ_underflow", m_occ, 1);
      if (acc == 1 && m_occ == DEPTH) chk("occ_overflow", m_occ, DEPTH - 1);
      m_occ = m_occ + acc - pp;
      if (m_own < 0) begin
        if (src0_req && src1_req) m_own = cfg_prio ? 0 : 1 - m_rr;
        else if (src0_req)        m_own = 0;
        else if (src1_req)        m_own = 1;
      end else if (acc == 1 && lst) begin
        if (m_own == 0) m_pc0 = (m_pc0 + 1) % (1 << PW);
        else            m_pc1 = (m_pc1 + 1) % (1 << PW);
        m_rr  = m_own;
        m_own = -1;
      end
    end
  end

  // ---------------- per-cycle compare, plus handshake logging for the stimulus driver
  bit hs[2];
  int gq[$];
  int tq[$];

  always @(negedge clk) begin
    bit t, e_req, e_r0, e_r1;
    int e_dat;
    hs[0] = src0_req && src0_ready;
    hs[1] = src1_req && src1_ready;
    if (hs[0]) begin gq.push_back(0); tq.push_back(cyc_n); end
    if (hs[1]) begin gq.push_back(1); tq.push_back(cyc_n); end
    if (started) begin
      t     = m_thr();
      e_req = (m_own == 0 && src0_req && !t) || (m_own == 1 && src1_req && !t);
      e_dat = !e_req ? 0 : (m_own == 0) ? int'(src0_data) : int'(src1_data);
      e_r0  = (m_own == 0) && fifo_wr_ready && !t;
      e_r1  = (m_own == 1) && fifo_wr_ready && !t;
      chk("wr_req",   int'(fifo_wr_req),  int'(e_req));
      chk("wr_data",  int'(fifo_wr_data), e_dat);
      chk("ready0",   int'(src0_ready),   int'(e_r0));
      chk("ready1",   int'(src1_ready),   int'(e_r1));
      chk("busy",     int'(arb_busy),     (m_own >= 0) ? 1 : 0);
      chk("occ",      int'(occ_count),    m_occ);
      chk("pkt_cnt0", int'(pkt_cnt0),     m_pc0);
      chk("pkt_cnt1", int'(pkt_cnt1),     m_pc1);
    end
  end

  // ---------------- stimulus driver: per-source packet plans
  int          pk_left[2], beat[2], len[2], lo[2], hi[2];
  logic [DW-1:0] dat[2];
  int          pop_mode = 0, pop_pct = 50;
  bit          rnd_wr_ready = 0;

  task automatic drive_src();
    src0_req  = pk_left[0] > 0;  src0_last = (beat[0] == len[0] - 1); src0_data = dat[0];
    src1_req  = pk_left[1] > 0;  src1_last = (beat[1] == len[1] - 1); src1_data = dat[1];
  endtask

  task automatic start_plan(input int s, input int n, input int l, input int h);
    pk_left[s] = n; lo[s] = l; hi[s] = h; beat[s] = 0;
    len[s] = $urandom_range(h, l);
    dat[s] = DW'($urandom);
    drive_src();
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      if (hs[s] && pk_left[s] > 0) begin
        beat[s]++;
        if (beat[s] >= len[s]) begin
          beat[s] = 0; pk_left[s]--;
          len[s] = $urandom_range(hi[s], lo[s]);
        end
        dat[s] = DW'($urandom);
      end
    end
    drive_src();
    if (pop_mode == 1) fifo_rd_req = (m_occ > 0) && ($urandom_range(0, 99) < pop_pct);
    if (pop_mode == 0) fifo_rd_req = 1'b0;
    if (rnd_wr_ready) fifo_wr_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int same, ones;
    pk_left = '{0, 0}; beat = '{0, 0}; len = '{1, 1}; lo = '{1, 1}; hi = '{1, 1};
    dat = '{0, 0};
    reset_ = 1'b0; cfg_prio = 1'b0; cfg_wmark = '0;
    fifo_wr_ready = 1'b1; fifo_rd_req = 1'b0; fifo_rd_ready = 1'b1;
    drive_src();
    cyc(); cyc();
    reset_ = 1'b1;
    chk("rst_occ", int'(occ_count), 0);
    chk("rst_busy", int'(arb_busy), 0);
    chk("rst_wr_req", int'(fifo_wr_req), 0);

    // 3-beat packet from src0, back-to-back accepts
    start_plan(0, 1, 3, 3);
    cyc();
    chk("t1_gnt_latency", int'(arb_busy), 1);
    cyc(); cyc(); cyc();
    chk("t1_idle", int'(arb_busy), 0);
    chk("t1_occ", int'(occ_count), 3);
    chk("t1_pkt0", int'(pkt_cnt0), 1);

    // round-robin with single-beat packets: strict alternation, one beat per 2 cycles
    pop_mode = 1;
    gq.delete(); tq.delete();
    start_plan(0, 10, 1, 1); start_plan(1, 10, 1, 1);
    for (int i = 0; i < 40; i++) cyc();
    chk("rr_beats", gq.size(), 20);
    chk("rr_first", (gq.size() > 0) ? gq[0] : -1, 1);
    same = 0;
    for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1] || tq[i] - tq[i-1] != 2) same++;
    chk("rr_alternate_spacing", same, 0);

    // fixed priority: src1 starved while src0 keeps requesting
    cfg_prio = 1'b1;
    gq.delete();
    start_plan(0, 5, 1, 2); start_plan(1, 3, 1, 1);
    for (int i = 0; i < 40 && pk_left[0] > 0; i++) cyc();
    chk("prio_src0_done", pk_left[0], 0);
    ones = 0;
    foreach (gq[i]) if (gq[i] == 1) ones++;
    chk("prio_starve", ones, 0);
    for (int i = 0; i < 20 && pk_left[1] > 0; i++) cyc();
    chk("prio_src1_after", pk_left[1], 0);
    cfg_prio = 1'b0;
    cyc(); cyc();

    // mid-packet reset after two of five beats
    pop_mode = 0;
    cyc();
    start_plan(0, 1, 5, 5);
    cyc(); cyc(); cyc();
    reset_ = 1'b0;
    cyc();
    chk("mrst_busy", int'(arb_busy), 0);
    chk("mrst_occ", int'(occ_count), 0);
    chk("mrst_ready0", int'(src0_ready), 0);
    chk("mrst_ready1", int'(src1_ready), 0);
    chk("mrst_pkt0", int'(pkt_cnt0), 0);
    pk_left = '{0, 0}; beat = '{0, 0};
    drive_src();
    reset_ = 1'b1;
    cyc();

    // watermark 4: stall with grant held, two pops release the last two beats
    cfg_wmark = CW'(4);
    start_plan(1, 1, 6, 6);
    for (int i = 0; i < 12; i++) cyc();
    chk("wm_occ_stall", int'(occ_count), 4);
    chk("wm_busy_held", int'(arb_busy), 1);
    chk("wm_wr_req", int'(fifo_wr_req), 0);
    chk("wm_ready1", int'(src1_ready), 0);
    pop_mode = 2;
    fifo_rd_req = 1'b1;
    cyc(); cyc();
    fifo_rd_req = 1'b0;
    for (int i = 0; i < 20 && pk_left[1] > 0; i++) cyc();
    cyc();
    chk("wm_done", pk_left[1], 0);
    chk("wm_occ_end", int'(occ_count), 4);
    chk("wm_pkt1", int'(pkt_cnt1), 1);

    // simultaneous accept and pop at occupancy 10
    cfg_wmark = '0;
    start_plan(0, 1, 6, 6);
    for (int i = 0; i < 20 && pk_left[0] > 0; i++) cyc();
    cyc();
    chk("sc_occ_before", int'(occ_count), 10);
    start_plan(0, 1, 1, 1);
    cyc();
    fifo_rd_req = 1'b1;
    cyc();
    fifo_rd_req = 1'b0;
    chk("sc_occ_same", int'(occ_count), 10);
    chk("sc_pkt0", int'(pkt_cnt0), 2);

    // randomized traffic, config and back-pressure
    pop_mode = 1; pop_pct = 60; rnd_wr_ready = 1;
    for (int i = 0; i < 600; i++) begin
      if (pk_left[0] == 0 && $urandom_range(0, 3) == 0) start_plan(0, $urandom_range(1, 3), 1, 4);
      if (pk_left[1] == 0 && $urandom_range(0, 3) == 0) start_plan(1, $urandom_range(1, 3), 1, 4);
      if ($urandom_range(0, 49) == 0) cfg_prio = 1'($urandom);
      if ($urandom_range(0, 39) == 0) cfg_wmark = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(3, 20));
      cyc();
    end
    pk_left = '{0, 0};
    drive_src();
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
